// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store stage in front of the 16-bit data memory.
package mem_access_pkg;

    localparam int LANE_W = 8;

    // Encodings of req_byte
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        WR     = 3'd4,
        RESP   = 3'd5
    } state_t;

    function automatic logic is_misaligned(input logic byte_access, input logic addr_lsb);
        return (byte_access == SIZE_WORD) && addr_lsb;
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Combinational byte-lane helpers: extract a lane with optional sign extension,
// and merge a byte into a lane of an existing word.
module byte_lane_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] ext_word,
    input  logic              ext_lane,
    input  logic              ext_sext,
    output logic [DATA_W-1:0] ext_result,
    input  logic [DATA_W-1:0] merge_word,
    input  logic              merge_lane,
    input  logic [LANE_W-1:0] merge_byte,
    output logic [DATA_W-1:0] merge_result
);

    localparam int NUM_LANES = DATA_W / LANE_W;

    logic [LANE_W-1:0] lane_sel;

    assign lane_sel   = ext_lane ? ext_word[2*LANE_W-1:LANE_W] : ext_word[LANE_W-1:0];
    assign ext_result = {{(DATA_W-LANE_W){ext_sext & lane_sel[LANE_W-1]}}, lane_sel};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_merge
            assign merge_result[gi*LANE_W +: LANE_W] =
                (int'(merge_lane) == gi) ? merge_byte : merge_word[gi*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: byte-address to word-index translation, byte loads with extension,
// byte stores via read-modify-write, and a one-cycle response pulse.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [15:0]       mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t state_reg, state_next;

    logic              we_q, byte_q, sext_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, merge_q, rdata_q;
    logic [DATA_W-1:0] ext_result, merge_result;
    logic              accept, misaligned;

    assign accept     = req_valid & req_ready;
    assign misaligned = is_misaligned(req_byte, req_addr[0]);

    byte_lane_unit #(.DATA_W(DATA_W)) u_lanes (
        .ext_word     (mem_read_data),
        .ext_lane     (addr_q[0]),
        .ext_sext     (sext_q),
        .ext_result   (ext_result),
        .merge_word   (mem_read_data),
        .merge_lane   (addr_q[0]),
        .merge_byte   (wdata_q[LANE_W-1:0]),
        .merge_result (merge_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (misaligned)                 state_next = RESP;
                    else if (!req_we)               state_next = RD;
                    else if (req_byte == SIZE_BYTE) state_next = RMW_RD;
                    else                            state_next = WR;
                end
            end
            RD, WR, RMW_WR: state_next = RESP;
            RMW_RD:         state_next = RMW_WR;
            RESP:           state_next = IDLE;
            default:        state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state_reg == IDLE) & ~rst;
        busy           = (state_reg != IDLE);
        resp_valid     = (state_reg == RESP);
        mem_read       = (state_reg == RD) || (state_reg == RMW_RD);
        mem_write_en   = ((state_reg == WR) || (state_reg == RMW_WR)) & ~rst;
        mem_write_data = '0;
        if (state_reg == WR)     mem_write_data = wdata_q;
        if (state_reg == RMW_WR) mem_write_data = merge_q;
    end

    // rdata_q is cleared at accept so stores and misaligned accesses answer with zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                byte_q  <= req_byte;
                sext_q  <= req_sext;
                err_q   <= misaligned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end
            if (state_reg == RD)     rdata_q <= (byte_q == SIZE_BYTE) ? ext_result : mem_read_data;
            if (state_reg == RMW_RD) merge_q <= merge_result;
        end
    end

    assign resp_err        = resp_valid & err_q & ~we_q | resp_valid & err_q & we_q;
    assign resp_rdata      = rdata_q;
    assign mem_access_addr = 16'({1'b0, addr_q[ADDR_W-1:1]});

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset corner cases,
// and randomized operations against a word-array reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_byte, req_sext;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [15:0] resp_rdata, mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_byte        (req_byte),
        .req_sext        (req_sext),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .busy            (busy),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    // Memory behind the unit: combinational read, write at posedge
    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];

    assign mem_read_data = mem[mem_access_addr[7:0]];
    always @(posedge clk) if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: architectural effect of one request on a plain word array
    task automatic ref_op(input logic we, input logic byt, input logic sext,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          output logic [15:0] e_rd, output logic e_err,
                          output int e_lat, output int e_reads, output int e_writes);
        int          widx;
        logic [15:0] word;
        logic [7:0]  b;
        widx = int'(addr[8:1]);
        word = ref_mem[widx];
        b    = addr[0] ? word[15:8] : word[7:0];
        e_rd = 16'h0000; e_err = 1'b0; e_reads = 0; e_writes = 0;
        if (!byt && addr[0]) begin
            e_err = 1'b1; e_lat = 1;
        end else if (!we) begin
            e_lat = 2; e_reads = 1;
            if (!byt)                e_rd = word;
            else if (sext && b[7])   e_rd = 16'hFF00 | {8'h00, b};
            else                     e_rd = {8'h00, b};
        end else if (!byt) begin
            e_lat = 2; e_writes = 1;
            ref_mem[widx] = wdata;
        end else begin
            e_lat = 3; e_reads = 1; e_writes = 1;
            if (addr[0]) ref_mem[widx] = {wdata[7:0], word[7:0]};
            else         ref_mem[widx] = {word[15:8], wdata[7:0]};
        end
    endtask

    task automatic do_op(input logic we, input logic byt, input logic sext,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         output logic [15:0] rdata, output logic err, output int lat,
                         output int reads, output int writes,
                         output logic [15:0] last_wd, output logic [15:0] last_ma);
        int k;
        @(negedge clk);
        chk("resp_pulse_len", resp_valid, 0);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_byte = byt; req_sext = sext;
        req_addr = addr; req_wdata = wdata;
        rdata = 16'hDEAD; err = 1'bx; lat = -1; reads = 0; writes = 0;
        last_wd = 16'h0000; last_ma = 16'hFFFF;
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        forever begin
            if (mem_read && mem_write_en) chk("strobe_exclusive", 1, 0);
            if (mem_read)     begin reads++;  last_ma = mem_access_addr; end
            if (mem_write_en) begin writes++; last_ma = mem_access_addr; last_wd = mem_write_data; end
            if (resp_valid) begin
                rdata = resp_rdata; err = resp_err; lat = k;
                break;
            end
            if (k >= 8) begin
                chk("resp_timeout", 0, 1);
                break;
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic run_checked(input logic we, input logic byt, input logic sext,
                               input logic [15:0] addr, input logic [15:0] wdata);
        logic [15:0] rd, e_rd, wd, ma;
        logic        er, e_err;
        int          lat, rds, wrs, e_lat, e_r, e_w;
        do_op(we, byt, sext, addr, wdata, rd, er, lat, rds, wrs, wd, ma);
        ref_op(we, byt, sext, addr, wdata, e_rd, e_err, e_lat, e_r, e_w);
        chk("rand_rdata", rd, e_rd);
        chk("rand_err", er, e_err);
        chk("rand_latency", lat, e_lat);
        chk("rand_reads", rds, e_r);
        chk("rand_writes", wrs, e_w);
        $display("op we=%0b byte=%0b sext=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 we, byt, sext, addr, wdata, rd, er, lat);
    endtask

    typedef struct {
        logic        we, byt, sext;
        logic [15:0] addr, wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [15:0] exp_wd, exp_ma;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [15:0] rd, e_rd, wd, ma;
        logic        er, e_err;
        int          lat, rds, wrs, e_lat, e_r, e_w, bad;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 16'hBEEF, 16'h0000, 1'b0, 2, 16'hBEEF, 16'h0002};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 2, 16'h0000, 16'h0002};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0005, 16'h0012, 16'h0000, 1'b0, 3, 16'h12EF, 16'h0002};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h12EF, 1'b0, 2, 16'h0000, 16'h0002};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 16'h0000, 16'hFFEF, 1'b0, 2, 16'h0000, 16'h0002};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h00EF, 1'b0, 2, 16'h0000, 16'h0002};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000, 16'h0012, 1'b0, 2, 16'h0000, 16'h0002};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000, 16'h0001};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'hAAAA, 16'h0000, 1'b1, 1, 16'h0000, 16'h0001};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b0, 2, 16'h0000, 16'h0001};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h12EF, 1'b0, 2, 16'h0000, 16'h0002};

        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0000; ref_mem[i] = 16'h0000;
        end
        req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_sext = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_write_en", mem_write_en, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_access_addr", mem_access_addr, 0);
        chk("rst_mem_write_data", mem_write_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].we, vecs[i].byt, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                  rd, er, lat, rds, wrs, wd, ma);
            ref_op(vecs[i].we, vecs[i].byt, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                   e_rd, e_err, e_lat, e_r, e_w);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_reads", i), rds, e_r);
            chk($sformatf("vec%0d_writes", i), wrs, e_w);
            if (e_r + e_w > 0) chk($sformatf("vec%0d_mem_addr", i), ma, vecs[i].exp_ma);
            if (e_w > 0)       chk($sformatf("vec%0d_mem_wdata", i), wd, vecs[i].exp_wd);
            $display("vec%0d addr=%h -> rdata=%h err=%0b lat=%0d reads=%0d writes=%0d",
                     i, vecs[i].addr, rd, er, lat, rds, wrs);
        end

        // Reset while idle
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_rst_req_ready", req_ready, 0);
        chk("idle_rst_mem_read", mem_read, 0);
        chk("idle_rst_mem_write_en", mem_write_en, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rst_release_ready", req_ready, 1);

        // Reset during RMW_WR of a byte store must not commit or respond
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_sext = 1'b0;
        req_addr = 16'h0005; req_wdata = 16'h0077;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_abort_read_phase", mem_read, 1);
        @(negedge clk);
        chk("rmw_abort_write_phase", mem_write_en, 1);
        rst = 1'b1;
        #1;
        chk("rmw_abort_we_drop", mem_write_en, 0);
        chk("rmw_abort_busy", busy, 0);
        chk("rmw_abort_resp", resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rmw_abort_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        chk("rmw_abort_mem_word", mem[2], 16'h12EF);
        $display("rmw abort: mem[2]=%h", mem[2]);
        run_checked(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000);

        // Randomized traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            run_checked(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 16'($urandom_range(0, 511)),
                        16'($urandom));
        end

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("final_memory_mismatches", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
